// File: rtl/level_prefix_decoder.sv
// CAVLC level decoder: reads a zero-run prefix and suffix from a bit FIFO and rebuilds levelCode/level.
// Define LEVEL_DEC_ESCAPE_EN to decode the prefix-14/15 escape codes; otherwise a 14-zero prefix is an error.
module level_prefix_decoder #(
  parameter int data_length = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2:0]                    suffix_len,
  input  logic                          first_adj,
  input  logic                          fifo_empty,
  input  logic                          fifo_data,
  output logic                          fifo_pop,
  output logic                          finish,
  output logic                          error,
  output logic [4:0]                    level_prefix,
  output logic [data_length:0]          level_code,
  output logic signed [data_length:0]   level
);

  localparam int LW = data_length + 1;

`ifdef LEVEL_DEC_ESCAPE_EN
  localparam logic [3:0] MAX_PREFIX = 4'd15;
`else
  localparam logic [3:0] MAX_PREFIX = 4'd13;
`endif

  typedef enum logic [2:0] {S_IDLE, S_PREFIX, S_SUFFIX, S_CALC, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_suffix_len;
  logic          r_first_adj;
  logic [3:0]    r_prefix;
  logic [11:0]   r_suffix;
  logic [3:0]    r_suffix_cnt;
  logic [3:0]    r_suffix_size;
  logic [3:0]    w_suffix_size;
  logic          w_escape_add;
  logic [LW-1:0] w_code;
  logic [LW:0]   w_mag;
  logic [LW-1:0] w_level;

  assign fifo_pop = !rst && ((r_state == S_PREFIX) || (r_state == S_SUFFIX)) && !fifo_empty;
  assign finish   = (r_state == S_DONE);

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_suffix_size = {1'b0, r_suffix_len};
    w_escape_add  = 1'b0;
`ifdef LEVEL_DEC_ESCAPE_EN
    if (r_prefix == 4'd15) begin
      w_suffix_size = 4'd12;
    end else if ((r_prefix == 4'd14) && (r_suffix_len == 3'd0)) begin
      w_suffix_size = 4'd4;
    end
    w_escape_add = (r_prefix == 4'd15) && (r_suffix_len == 3'd0);
`endif
  end

  always_comb begin
    w_code = (LW'(r_prefix) << r_suffix_len) + LW'(r_suffix)
           + (w_escape_add ? LW'(15) : LW'(0))
           + (r_first_adj  ? LW'(2)  : LW'(0));
    // Even codes map to positive levels, odd codes to negative ones.
    w_mag   = w_code[0] ? ({1'b0, w_code} + 1'b1) >> 1 : ({1'b0, w_code} + 2'd2) >> 1;
    w_level = w_code[0] ? -w_mag[LW-1:0] : w_mag[LW-1:0];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_PREFIX;
      S_PREFIX: begin
        if (fifo_pop) begin
          if (fifo_data)                    w_next = (w_suffix_size == 4'd0) ? S_CALC : S_SUFFIX;
          else if (r_prefix == MAX_PREFIX)  w_next = S_DONE;
        end
      end
      S_SUFFIX: if (fifo_pop && ((r_suffix_cnt + 4'd1) == r_suffix_size)) w_next = S_CALC;
      S_CALC:   w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_suffix_len  <= '0;
      r_first_adj   <= 1'b0;
      r_prefix      <= '0;
      r_suffix      <= '0;
      r_suffix_cnt  <= '0;
      r_suffix_size <= '0;
      error         <= 1'b0;
      level_prefix  <= '0;
      level_code    <= '0;
      level         <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_suffix_len <= suffix_len;
            r_first_adj  <= first_adj;
            r_prefix     <= '0;
            r_suffix     <= '0;
            r_suffix_cnt <= '0;
          end
        end
        S_PREFIX: begin
          if (fifo_pop) begin
            if (fifo_data) begin
              r_suffix_size <= w_suffix_size;
            end else if (r_prefix == MAX_PREFIX) begin
              error        <= 1'b1;
              level_prefix <= 5'(r_prefix) + 5'd1;
              level_code   <= '0;
              level        <= '0;
            end else begin
              r_prefix <= r_prefix + 4'd1;
            end
          end
        end
        S_SUFFIX: begin
          if (fifo_pop) begin
            r_suffix     <= {r_suffix[10:0], fifo_data};
            r_suffix_cnt <= r_suffix_cnt + 4'd1;
          end
        end
        S_CALC: begin
          error        <= 1'b0;
          level_prefix <= 5'(r_prefix);
          level_code   <= w_code;
          level        <= $signed(w_level);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_level_prefix_decoder.sv
// Scoreboard bench for level_prefix_decoder: directed vectors push expectations, a negedge monitor checks finishes.
module tb_level_prefix_decoder;

  localparam int DL = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [2:0]        suffix_len;
  logic              first_adj;
  logic              fifo_empty;
  logic              fifo_data;
  logic              fifo_pop;
  logic              finish;
  logic              error;
  logic [4:0]        level_prefix;
  logic [DL:0]       level_code;
  logic signed [DL:0] level;

  level_prefix_decoder #(.data_length(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .suffix_len(suffix_len), .first_adj(first_adj),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop), .finish(finish),
    .error(error), .level_prefix(level_prefix), .level_code(level_code), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prefix;
    int code;
    int lvl;
    int err;
    int lat;
    int pops;
  } exp_t;

  exp_t exp_q[$];
  bit   fifo_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   pop_cnt = 0;
  int   done_cnt = 0;
  int   stall_at = -1;
  int   stall_left = 0;
  logic stall = 1'b0;
  logic pop_flag = 1'b0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0) || stall;
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: consumes the bit the DUT popped, then optionally holds the FIFO empty.
  always @(posedge clk) begin
    #1;
    if (pop_flag && fifo_q.size() > 0) void'(fifo_q.pop_front());
    pop_flag = 1'b0;
    if (stall_left > 0 && fifo_q.size() == stall_at) begin
      stall = 1'b1;
      stall_left--;
    end else begin
      stall = 1'b0;
    end
    refresh_fifo();
  end

  always @(negedge clk) begin
    exp_t e;
    pop_flag = fifo_pop;
    if (fifo_pop) pop_cnt++;
    if (fifo_pop && fifo_empty) check("pop_while_empty", 1, 0);
    if (finish) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_finish", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("error", int'(error), e.err);
        check("level_code", int'(level_code), e.code);
        check("level", int'(level), e.lvl);
        if (e.err == 0) check("level_prefix", int'(level_prefix), e.prefix);
        check("latency", cyc - start_cyc, e.lat);
        check("pops", pop_cnt, e.pops);
      end
    end
  end

  task automatic run(input logic [2:0] sl, input logic fa, input logic [31:0] bits, input int n,
                     input exp_t e, input int st_at, input int st_len);
    int target;
    @(posedge clk); #2;
    fifo_q.delete();
    for (int i = n - 1; i >= 0; i--) fifo_q.push_back(bits[i]);
    stall_at   = st_at;
    stall_left = st_len;
    refresh_fifo();
    suffix_len = sl;
    first_adj  = fa;
    start      = 1'b1;
    start_cyc  = cyc;
    pop_cnt    = 0;
    exp_q.push_back(e);
    target = done_cnt + 1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int k = 0; k < 200 && done_cnt < target; k++) @(posedge clk);
    check("finish_seen", done_cnt, target);
    exp_q.delete();
    @(posedge clk);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_finish"}, int'(finish), 0);
    check({tag, "_error"}, int'(error), 0);
    check({tag, "_level_prefix"}, int'(level_prefix), 0);
    check({tag, "_level_code"}, int'(level_code), 0);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_fifo_pop"}, int'(fifo_pop), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; suffix_len = '0; first_adj = 1'b0;
    refresh_fifo();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    @(posedge clk); #2;
    rst = 1'b0;

    //   sl  fa  bits                 n   prefix code lvl err lat pops
    run(3'd0, 1'b0, 32'b0001,       4, '{3, 3, -2, 0, 6, 4}, -1, 0);
    run(3'd2, 1'b0, 32'b0110,       4, '{1, 6, 4, 0, 6, 4}, -1, 0);
    run(3'd0, 1'b1, 32'b1,          1, '{0, 2, 2, 0, 3, 1}, -1, 0);
    run(3'd2, 1'b1, 32'b0110,       4, '{1, 8, 5, 0, 6, 4}, -1, 0);
    run(3'd1, 1'b0, 32'b11,         2, '{0, 1, -1, 0, 4, 2}, -1, 0);
    run(3'd6, 1'b0, 32'b01101010,   8, '{1, 106, 54, 0, 10, 8}, -1, 0);
    run(3'd0, 1'b0, 32'b0001,       4, '{3, 3, -2, 0, 11, 4}, 2, 5);
    run(3'd0, 1'b0, 32'b00000000000001, 14, '{13, 13, -7, 0, 16, 14}, -1, 0);
`ifdef LEVEL_DEC_ESCAPE_EN
    run(3'd0, 1'b0, 32'b0000000000000010101, 19, '{14, 19, -10, 0, 21, 19}, -1, 0);
    run(3'd0, 1'b0, 32'b0000000000000001000000000001, 28, '{15, 31, -16, 0, 30, 28}, -1, 0);
    run(3'd0, 1'b0, 32'b0000000000000000, 16, '{16, 0, 0, 1, 17, 16}, -1, 0);
`else
    run(3'd0, 1'b0, 32'b0000000000000010101, 19, '{14, 0, 0, 1, 15, 14}, -1, 0);
`endif

    // Reset in the middle of a suffix: nothing may be reported, then a clean decode follows.
    run(3'd2, 1'b0, 32'b0110, 4, '{1, 6, 4, 0, 6, 4}, -1, 0);
    @(posedge clk); #2;
    fifo_q.delete();
    for (int i = 4; i >= 0; i--) fifo_q.push_back(i[0] ^ 1'b1);
    refresh_fifo();
    suffix_len = 3'd4;
    start      = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("pop_in_reset", int'(fifo_pop), 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check_cleared("mid_reset");
    repeat (30) @(posedge clk);
    run(3'd0, 1'b0, 32'b0001, 4, '{3, 3, -2, 0, 6, 4}, -1, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
